stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ptr.sv | 35 +++
 rtl/stream_fifo.sv | 121 ++++++++++++
 tb/tb_stream_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the FIFO family.
//   level_width  : bits needed to hold a fill level of 0..depth
//   ptr_width    : bits needed to index 0..depth-1
//   ptr_wrap_inc : pointer increment that wraps depth-1 -> 0 explicitly,
//                  so non power-of-two depths work.
package fifo_pkg;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 32'd1 : $clog2(depth);
  endfunction

  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                               input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping index register 0..DEPTH-1.
//   clk_i      rising-edge clock
//   reset_n_i  async active-low reset, pointer -> 0
//   clear_i    synchronous return to 0, wins over advance_i
//   advance_i  step by one, wrapping DEPTH-1 -> 0
//   ptr_o      current pointer
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i)        ptr_d = '0;
    else if (advance_i) ptr_d = PW'(ptr_wrap_inc(32'(ptr_q), DEPTH));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock first-word-fall-through FIFO, valid/ready on
// both sides, any DEPTH >= 2, all entries usable.
//   clk_i, reset_n_i       clock, async active-low reset
//   flush_i                synchronous discard of all entries
//   in_valid_i/in_ready_o/in_value_i     write side
//   out_valid_o/out_ready_i/out_value_o  read side (head word, no latency
//                                        beyond the push edge)
//   level_o                stored entry count 0..DEPTH
//   almost_full_o          level_o >= AFULL_LEVEL
//   almost_empty_o         level_o <= AEMPTY_LEVEL
//   overflow_o             sticky: write attempted while not ready
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int VALUE_WIDTH  = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int LW          = level_width(DEPTH),
  localparam int PW          = ptr_width(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [VALUE_WIDTH-1:0] in_value_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [VALUE_WIDTH-1:0] out_value_o,
  output logic [LW-1:0]          level_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   overflow_o
);

  // Parameter legality, caught at elaboration.
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "stream_fifo: DEPTH must be >= 2");
  end
  if (VALUE_WIDTH < 1) begin : g_bad_width
    $fatal(1, "stream_fifo: VALUE_WIDTH must be >= 1");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $fatal(1, "stream_fifo: AFULL_LEVEL must be in 1..DEPTH");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "stream_fifo: AEMPTY_LEVEL must be in 0..DEPTH-1");
  end

  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] LVL_AEMPTY = LW'(AEMPTY_LEVEL);

  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [PW-1:0]          wptr, rptr;
  logic                   push, pop;
  logic [VALUE_WIDTH-1:0] mem_q [DEPTH];

  // Ready only looks at the registered level and flush, so there is no
  // combinational path from out_ready_i: a full FIFO refuses a write even
  // when the same edge pops.
  assign in_ready_o  = (level_q != LVL_FULL) & ~flush_i;
  assign out_valid_o = (level_q != '0);

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .advance_i (push),
    .ptr_o     (wptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .advance_i (pop),
    .ptr_o     (rptr)
  );

  always_comb begin
    level_d = level_q;
    // A flush cycle is not an overflow: in_ready_o is low only because of
    // the flush itself.
    ovf_d   = ovf_q | (in_valid_i & ~in_ready_o & ~flush_i);
    if (flush_i)          level_d = '0;
    else if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage carries no reset; only slots that are pushed get written, and a
  // push can only target a free slot, so unread data is never clobbered.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr] <= in_value_i;
  end

  assign out_value_o    = mem_q[rptr];
  assign level_o        = level_q;
  assign almost_full_o  = (level_q >= LVL_AFULL);
  assign almost_empty_o = (level_q <= LVL_AEMPTY);
  assign overflow_o     = ovf_q;

  a_level_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    level_q <= LVL_FULL);

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;
  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int LW = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush, in_valid, out_ready;
  logic [W-1:0] in_value;
  logic         in_ready, out_valid, afull, aempty, ovf;
  logic [W-1:0] out_value;
  logic [LW-1:0] level;

  stream_fifo #(.VALUE_WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_value_i     (in_value),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_value_o    (out_value),
    .level_o        (level),
    .almost_full_o  (afull),
    .almost_empty_o (aempty),
    .overflow_o     (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored words plus the sticky flag.
  logic [W-1:0] q[$];
  bit           ovf_m = 1'b0;
  int           n_chk = 0;
  int           n_pass = 0;
  bit           cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      bit full, psh, pp;
      full = (q.size() == D);
      psh  = in_valid && !full && !flush;
      pp   = (q.size() != 0) && out_ready && !flush;
      if (in_valid && full && !flush) ovf_m = 1'b1;
      if (flush) q.delete();
      else begin
        if (pp)  void'(q.pop_front());
        if (psh) q.push_back(in_value);
      end
    end
  end

  // Every cycle: outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",     32'(in_ready),  32'((q.size() != D) && !flush));
      chk("out_valid",    32'(out_valid), 32'(q.size() != 0));
      chk("level",        32'(level),     32'(q.size()));
      chk("almost_full",  32'(afull),     32'(q.size() >= AF));
      chk("almost_empty", 32'(aempty),    32'(q.size() <= AE));
      chk("overflow",     32'(ovf),       32'(ovf_m));
      if (q.size() != 0) chk("out_value", 32'(out_value), 32'(q[0]));
    end
  end

  // Present inputs for one edge, then return to idle just after it.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid = v; in_value = d; out_ready = r; flush = f;
    @(posedge clk); #1;
    in_valid = 1'b0; in_value = '0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_level"},     32'(level),     32'd0);
    chk({tag, "_afull"},     32'(afull),     32'd0);
    chk({tag, "_aempty"},    32'(aempty),    32'd1);
    chk({tag, "_overflow"},  32'(ovf),       32'd0);
  endtask

  logic [W-1:0] wrap_exp [5];
  int push_pct;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Fill 0x11..0x55 with no reads.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, W'(i * 8'h11), 1'b0, 1'b0);
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_afull", 32'(afull), 32'(i >= 4));
    end
    chk("fill_in_ready", 32'(in_ready),  32'd0);
    chk("fill_head",     32'(out_value), 32'h11);

    // Write at full: overflow, sticky.
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("ovf_set",   32'(ovf),   32'd1);
    chk("ovf_level", 32'(level), 32'd5);
    // Full with both sides active: pop only.
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    chk("fullpp_level", 32'(level),     32'd4);
    chk("fullpp_head",  32'(out_value), 32'h22);
    // Flush wins over concurrent push/pop and leaves overflow alone.
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_level", 32'(level),     32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ovf",   32'(ovf),       32'd1);

    // Wrap: push 5, pop 3, push 3, drain.
    for (int i = 1; i <= 5; i++) cyc(1'b1, W'(i * 8'h11), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
    chk("wrap_level", 32'(level), 32'd5);
    wrap_exp = '{8'h44, 8'h55, 8'hA0, 8'hA1, 8'hA2};
    for (int i = 0; i < 5; i++) begin
      chk("wrap_order", 32'(out_value), 32'(wrap_exp[i]));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("wrap_empty", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at level 2.
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, W'(8'h10 + i), 1'b1, 1'b0);
      chk("simul_level", 32'(level), 32'd2);
    end
    chk("simul_head", 32'(out_value), 32'h18);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Async reset pulse between edges at level 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(8'hC1 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    #1 rst_n = 1'b1;
    cyc(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_head",  32'(out_value), 32'h7E);
    chk("post_rst_level", 32'(level),     32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 10000; i++) begin
      push_pct = ((i / 500) % 2 != 0) ? 70 : 30;
      cyc(1'($urandom_range(0, 99) < push_pct), W'($urandom),
          1'($urandom_range(0, 99) < (100 - push_pct)),
          1'($urandom_range(0, 255) == 0));
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
